// File: rtl/spi_rx_pkg.sv
// Shared types and field widths for the SPI write receiver.
package spi_rx_pkg;

    localparam int CMD_W   = 8;
    localparam int ADDR_W  = 24;
    localparam int DATA_W  = 32;
    localparam int FRAME_W = CMD_W + ADDR_W + DATA_W;
    localparam int CNT_W   = 6;

    localparam logic [CMD_W-1:0] WRITE_CMD_DEFAULT = 8'hA4;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        HOLD
    } rx_state_e;

endpackage

// File: rtl/spi_rx_shifter.sv
// MSB-first frame shift register and bit counter for the SPI receiver.
module spi_rx_shifter
    import spi_rx_pkg::*;
(
    input  logic               sck,
    input  logic               rst,
    input  logic               clear_i,
    input  logic               shift_en_i,
    input  logic               bit_i,
    output logic [FRAME_W-1:0] frame_o,
    output logic [CNT_W-1:0]   count_o
);

    logic [FRAME_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]   count_q, count_d;

    always_comb begin
        shift_d = shift_q;
        count_d = count_q;
        if (clear_i) begin
            shift_d = '0;
            count_d = '0;
        end else if (shift_en_i) begin
            shift_d = {shift_q[FRAME_W-2:0], bit_i};
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge sck or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            count_q <= '0;
        end else begin
            shift_q <= shift_d;
            count_q <= count_d;
        end
    end

    // While shifting, expose the frame including the bit being sampled now,
    // so the last bit can be committed on the same edge that samples it.
    assign frame_o = shift_en_i ? {shift_q[FRAME_W-2:0], bit_i} : shift_q;
    assign count_o = count_q;

endmodule

// File: rtl/spi_receiver.sv
// SPI write receiver: 8-bit command, 24-bit address, 32-bit data per cs frame.
// Define SPI_RX_FRAME_ERR_EN to add the frame_err_out abort/bad-command pulse.
module spi_receiver
    import spi_rx_pkg::*;
#(
    parameter logic [CMD_W-1:0] WRITE_CMD = WRITE_CMD_DEFAULT
) (
    input  logic              sck,
    input  logic              rst,
    input  logic              cs,
    input  logic              copi,
    output logic              wr_en_out,
    output logic [ADDR_W-1:0] wr_address_out,
    output logic [DATA_W-1:0] wr_data_out
`ifdef SPI_RX_FRAME_ERR_EN
    ,
    output logic              frame_err_out
`endif
);

    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_W - 1);
    localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(CMD_W + ADDR_W - 1);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_W - 1);

    rx_state_e          state_q, state_d;
    logic               armed_q;
    logic               shift_en, clear, commit;
    logic [FRAME_W-1:0] frame;
    logic [CNT_W-1:0]   count;
    logic               wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;
`ifdef SPI_RX_FRAME_ERR_EN
    logic               frame_err_q, frame_err_d;
`endif

    spi_rx_shifter u_shifter (
        .sck        (sck),
        .rst        (rst),
        .clear_i    (clear),
        .shift_en_i (shift_en),
        .bit_i      (copi),
        .frame_o    (frame),
        .count_o    (count)
    );

    // armed_q blocks a frame already in flight across reset from being taken
    // as new; a high cs sample must be seen first.
    always_ff @(posedge sck or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_q | cs;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_en  = 1'b0;
        clear     = 1'b0;
        commit    = 1'b0;
`ifdef SPI_RX_FRAME_ERR_EN
        frame_err_d = 1'b0;
`endif
        if (cs) begin
            state_d = IDLE;
            clear   = 1'b1;
`ifdef SPI_RX_FRAME_ERR_EN
            frame_err_d = (state_q == CMD) || (state_q == ADDR) || (state_q == DATA);
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (armed_q) begin
                        state_d  = CMD;
                        shift_en = 1'b1;
                    end
                end
                CMD: begin
                    shift_en = 1'b1;
                    if (count == CMD_LAST) state_d = ADDR;
                end
                ADDR: begin
                    shift_en = 1'b1;
                    if (count == ADDR_LAST) state_d = DATA;
                end
                DATA: begin
                    shift_en = 1'b1;
                    if (count == FRAME_LAST) begin
                        state_d = HOLD;
                        commit  = (frame[FRAME_W-1 -: CMD_W] == WRITE_CMD);
`ifdef SPI_RX_FRAME_ERR_EN
                        frame_err_d = (frame[FRAME_W-1 -: CMD_W] != WRITE_CMD);
`endif
                    end
                end
                HOLD: begin
                end
                default: state_d = IDLE;
            endcase
        end

        wr_en_d   = commit;
        wr_addr_d = commit ? frame[DATA_W +: ADDR_W] : wr_addr_q;
        wr_data_d = commit ? frame[DATA_W-1:0]       : wr_data_q;
    end

    always_ff @(posedge sck or posedge rst) begin
        if (rst) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

`ifdef SPI_RX_FRAME_ERR_EN
    always_ff @(posedge sck or posedge rst) begin
        if (rst) frame_err_q <= 1'b0;
        else     frame_err_q <= frame_err_d;
    end

    assign frame_err_out = frame_err_q;
`endif

    assign wr_en_out      = wr_en_q;
    assign wr_address_out = wr_addr_q;
    assign wr_data_out    = wr_data_q;

endmodule

// File: tb/tb_spi_receiver.sv
// Scoreboard bench for spi_receiver: directed frames plus randomized frames.
// Covers frame_err_out when SPI_RX_FRAME_ERR_EN is defined.
module tb_spi_receiver;

    localparam logic [7:0] WCMD = 8'hA4;

    logic        sck = 1'b0;
    logic        rst = 1'b1;
    logic        cs = 1'b1;
    logic        copi = 1'b0;
    logic        wr_en_out;
    logic [23:0] wr_address_out;
    logic [31:0] wr_data_out;
`ifdef SPI_RX_FRAME_ERR_EN
    logic        frame_err_out;
`endif

    typedef struct {
        int          cyc;
        logic [23:0] addr;
        logic [31:0] data;
    } commit_t;

    commit_t     expQ[$];
    int          errQ[$];
    logic [23:0] modelAddr = '0;
    logic [31:0] modelData = '0;
    int          cycleCnt = 0;
    int          checks = 0;
    int          errors = 0;

    spi_receiver #(.WRITE_CMD(WCMD)) dut (
        .sck            (sck),
        .rst            (rst),
        .cs             (cs),
        .copi           (copi),
        .wr_en_out      (wr_en_out),
        .wr_address_out (wr_address_out),
        .wr_data_out    (wr_data_out)
`ifdef SPI_RX_FRAME_ERR_EN
        ,
        .frame_err_out  (frame_err_out)
`endif
    );

    always #5 sck = ~sck;

    always @(posedge sck) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cycleCnt);
        end
    endtask

    // Expected behaviour follows the frame rules directly: the 64th bit of a
    // write-command frame commits, anything shorter is an abort.
    task automatic applyStimulus(input logic [63:0] f, input int nbits, input logic [7:0] extra);
        logic [71:0] b;
        commit_t     c;
        b = {f, extra};
        for (int i = 0; i < nbits; i++) begin
            @(negedge sck);
            cs   = 1'b0;
            copi = b[71-i];
            if (i == 63) begin
                if (f[63:56] == WCMD) begin
                    c.cyc  = cycleCnt + 1;
                    c.addr = f[55:32];
                    c.data = f[31:0];
                    expQ.push_back(c);
                end else begin
                    errQ.push_back(cycleCnt + 1);
                end
            end
        end
        @(negedge sck);
        cs   = 1'b1;
        copi = 1'($urandom);
        if (nbits > 0 && nbits < 64) errQ.push_back(cycleCnt + 1);
    endtask

    task automatic pulseReset();
        @(negedge sck);
        #2 rst = 1'b1;
        expQ.delete();
        errQ.delete();
        modelAddr = '0;
        modelData = '0;
        #1;
        checkOutput("rst_wr_en", 64'(wr_en_out), 64'd0);
        checkOutput("rst_addr", 64'(wr_address_out), 64'd0);
        checkOutput("rst_data", 64'(wr_data_out), 64'd0);
`ifdef SPI_RX_FRAME_ERR_EN
        checkOutput("rst_frame_err", 64'(frame_err_out), 64'd0);
`endif
        @(negedge sck);
        rst = 1'b0;
    endtask

    // Monitor: pops expected commits when the strobe appears, flags missed or
    // extra strobes, and checks the outputs hold between commits.
    initial begin
        commit_t e;
        forever begin
            @(posedge sck);
            #1;
            if (!rst) begin
                if (wr_en_out) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected_strobe", 64'd1, 64'd0);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("strobe_cycle", 64'(cycleCnt), 64'(e.cyc));
                        modelAddr = e.addr;
                        modelData = e.data;
                    end
                end else if (expQ.size() > 0 && expQ[0].cyc <= cycleCnt) begin
                    e = expQ.pop_front();
                    checkOutput("missed_strobe", 64'd0, 64'd1);
                    modelAddr = e.addr;
                    modelData = e.data;
                end
                checkOutput("wr_address", 64'(wr_address_out), 64'(modelAddr));
                checkOutput("wr_data", 64'(wr_data_out), 64'(modelData));
`ifdef SPI_RX_FRAME_ERR_EN
                if (frame_err_out) begin
                    if (errQ.size() == 0) checkOutput("unexpected_frame_err", 64'd1, 64'd0);
                    else checkOutput("frame_err_cycle", 64'(cycleCnt), 64'(errQ.pop_front()));
                end else if (errQ.size() > 0 && errQ[0] <= cycleCnt) begin
                    void'(errQ.pop_front());
                    checkOutput("missed_frame_err", 64'd0, 64'd1);
                end
`endif
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cycleCnt);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] f;
        logic [7:0]  cmd;
        int          nb;

        #1;
        checkOutput("init_wr_en", 64'(wr_en_out), 64'd0);
        checkOutput("init_addr", 64'(wr_address_out), 64'd0);
        checkOutput("init_data", 64'(wr_data_out), 64'd0);
        repeat (2) @(negedge sck);
        rst = 1'b0;
        @(negedge sck);
        cs = 1'b1;

        $display("[TB] basic write frame");
        applyStimulus(64'hA4123456_DEADBEEF, 64, 8'h00);
        $display("[TB] non-write command frame");
        applyStimulus(64'hA1123456_DEADBEEF, 64, 8'h00);
        $display("[TB] abort after 40 bits, then fresh frame");
        applyStimulus(64'hA4ABCDEF_01234567, 40, 8'h00);
        applyStimulus(64'hA4000001_00000002, 64, 8'h00);
        $display("[TB] 72-bit frame with trailing FF");
        applyStimulus(64'hA4CAFE00_87654321, 72, 8'hFF);

        $display("[TB] reset mid-frame");
        f = 64'hA4777777_55555555;
        for (int i = 0; i < 20; i++) begin
            @(negedge sck);
            cs   = 1'b0;
            copi = f[63-i];
        end
        pulseReset();
        for (int i = 0; i < 64; i++) begin
            @(negedge sck);
            cs   = 1'b0;
            copi = f[63-i];
        end
        @(negedge sck);
        cs = 1'b1;
        applyStimulus(64'hA4111111_22222222, 64, 8'h00);

        $display("[TB] back-to-back frames");
        applyStimulus(64'hA4010203_04050607, 64, 8'h00);
        applyStimulus(64'hA4F0E0D0_C0B0A090, 64, 8'h00);

        $display("[TB] randomized frames");
        for (int n = 0; n < 24; n++) begin
            cmd = ($urandom_range(0, 2) != 0) ? WCMD : 8'($urandom);
            f   = {cmd, 24'($urandom), 32'($urandom)};
            case ($urandom_range(0, 5))
                0:       nb = $urandom_range(1, 63);
                1:       nb = $urandom_range(65, 72);
                default: nb = 64;
            endcase
            applyStimulus(f, nb, 8'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge sck);
        end

        repeat (4) @(negedge sck);
        checkOutput("pending_strobes", 64'(expQ.size()), 64'd0);
`ifdef SPI_RX_FRAME_ERR_EN
        checkOutput("pending_frame_errs", 64'(errQ.size()), 64'd0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
